// File: rtl/arrow_hit_detect.sv
// arrow_hit_detect: per-frame arrow collision arbiter producing crash/hit pulses
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   startOfFrame       one-cycle frame boundary pulse
//   arrowTopY          arrow top Y, 11'h7FF when no arrow is in flight
//   arrowDR/ballDR/borderDR  pixel drawing requests of arrow, balls, border
//   crash              one-cycle pulse telling the mover to retire the arrow
//   ballHit            one-hot struck ball, coincident with crash
//   ceilingHit         crash caused by ceiling/border only
//   hitCount           saturating ball-hit count since reset
module arrow_hit_detect #(
    parameter int          NUM_BALLS       = 4,
    parameter logic [10:0] TOP_Y           = 11'd8,
    parameter int          MAX_WAIT_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [10:0]          arrowTopY,
    input  logic                 arrowDR,
    input  logic [NUM_BALLS-1:0] ballDR,
    input  logic                 borderDR,
    output logic                 crash,
    output logic [NUM_BALLS-1:0] ballHit,
    output logic                 ceilingHit,
    output logic [7:0]           hitCount
);
    localparam int          CW       = $clog2(MAX_WAIT_FRAMES + 1);
    localparam logic [10:0] NO_ARROW = 11'h7FF;
    typedef enum logic [1:0] {ARMED, REPORT, WAIT_CLEAR} state_t;
    state_t               state_q, state_d;
    logic [NUM_BALLS-1:0] ball_flag_q, ball_flag_d;
    logic                 wall_flag_q, wall_flag_d;
    logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
    logic                 crash_q, crash_d;
    logic [NUM_BALLS-1:0] ball_hit_q, ball_hit_d;
    logic                 ceil_hit_q, ceil_hit_d;
    logic [7:0]           hit_cnt_q, hit_cnt_d;
    logic                 active, wall_any, ceil;
    logic [NUM_BALLS-1:0] ball_any, lowest_ball;
    always_comb begin
        active      = arrowTopY != NO_ARROW;
        // the current pixel is folded in so the startOfFrame cycle counts too
        ball_any    = ball_flag_q | ({NUM_BALLS{active & arrowDR}} & ballDR);
        wall_any    = wall_flag_q | (active & arrowDR & borderDR);
        ceil        = active & (arrowTopY <= TOP_Y);
        lowest_ball = ball_any & (~ball_any + NUM_BALLS'(1));
        state_d     = state_q;
        ball_flag_d = '0;
        wall_flag_d = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        crash_d     = 1'b0;
        ball_hit_d  = '0;
        ceil_hit_d  = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        case (state_q)
            ARMED: begin
                if (startOfFrame) begin
                    if (|ball_any || wall_any || ceil) begin
                        state_d    = REPORT;
                        crash_d    = 1'b1;
                        ball_hit_d = lowest_ball;
                        ceil_hit_d = ~|ball_any;
                        hit_cnt_d  = (|ball_any && hit_cnt_q != 8'hFF) ? hit_cnt_q + 8'd1 : hit_cnt_q;
                    end
                end else begin
                    ball_flag_d = ball_any;
                    wall_flag_d = wall_any;
                end
            end
            REPORT: begin
                state_d    = WAIT_CLEAR;
                wait_cnt_d = '0;
            end
            WAIT_CLEAR: begin
                // frame timeout guards against a mover that never clears the arrow
                if (!active) begin
                    state_d = ARMED;
                end else if (startOfFrame) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                    state_d    = (wait_cnt_d == CW'(MAX_WAIT_FRAMES)) ? ARMED : WAIT_CLEAR;
                end
            end
            default: state_d = ARMED;
        endcase
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ARMED;
            ball_flag_q <= '0;
            wall_flag_q <= 1'b0;
            wait_cnt_q  <= '0;
            crash_q     <= 1'b0;
            ball_hit_q  <= '0;
            ceil_hit_q  <= 1'b0;
            hit_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            ball_flag_q <= ball_flag_d;
            wall_flag_q <= wall_flag_d;
            wait_cnt_q  <= wait_cnt_d;
            crash_q     <= crash_d;
            ball_hit_q  <= ball_hit_d;
            ceil_hit_q  <= ceil_hit_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end
    assign crash      = crash_q;
    assign ballHit    = ball_hit_q;
    assign ceilingHit = ceil_hit_q;
    assign hitCount   = hit_cnt_q;
endmodule

// File: tb/tb_arrow_hit_detect.sv
// tb_arrow_hit_detect: directed vectors and corner sequences for arrow_hit_detect
module tb_arrow_hit_detect;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] arrowTopY = 11'h7FF;
    logic        arrowDR = 1'b0;
    logic [3:0]  ballDR = 4'b0;
    logic        borderDR = 1'b0;
    logic        crash;
    logic [3:0]  ballHit;
    logic        ceilingHit;
    logic [7:0]  hitCount;
    int          errors = 0;
    int          checks = 0;
    arrow_hit_detect dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .arrowTopY(arrowTopY),
        .arrowDR(arrowDR), .ballDR(ballDR), .borderDR(borderDR),
        .crash(crash), .ballHit(ballHit), .ceilingHit(ceilingHit), .hitCount(hitCount)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        sof;
        logic [10:0] y;
        logic        adr;
        logic [3:0]  bdr;
        logic        brd;
        logic        crash;
        logic [3:0]  bh;
        logic        ceil;
        logic [7:0]  cnt;
    } vec_t;
    vec_t vecs[$];
    function automatic vec_t v(input logic sof, input logic [10:0] y, input logic adr, input logic [3:0] bdr,
                               input logic brd, input logic c, input logic [3:0] bh, input logic ce, input logic [7:0] cnt);
        vec_t r;
        r.sof = sof; r.y = y; r.adr = adr; r.bdr = bdr; r.brd = brd;
        r.crash = c; r.bh = bh; r.ceil = ce; r.cnt = cnt;
        return r;
    endfunction
    task automatic check(input string name, input logic c, input logic [3:0] bh, input logic ce, input logic [7:0] cnt);
        checks++;
        if (crash !== c || ballHit !== bh || ceilingHit !== ce || hitCount !== cnt) begin
            errors++;
            $display("FAIL %s: got crash=%b ballHit=%b ceilingHit=%b hitCount=%0d, expected %b %b %b %0d",
                     name, crash, ballHit, ceilingHit, hitCount, c, bh, ce, cnt);
        end
    endtask
    task automatic step(input logic sof, input logic [10:0] y, input logic adr, input logic [3:0] bdr, input logic brd);
        startOfFrame = sof; arrowTopY = y; arrowDR = adr; ballDR = bdr; borderDR = brd;
        @(posedge clk);
        #1;
    endtask
    initial begin
        int exp_cnt;
        int late_crash;
        vecs.push_back(v(0, 300, 1, 4'b0100, 0, 0, 4'b0000, 0, 0));
        vecs.push_back(v(0, 300, 0, 4'b0000, 0, 0, 4'b0000, 0, 0));
        vecs.push_back(v(1, 300, 0, 4'b0000, 0, 1, 4'b0100, 0, 1));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 1));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 1));
        vecs.push_back(v(0, 300, 1, 4'b1010, 0, 0, 4'b0000, 0, 1));
        vecs.push_back(v(1, 300, 0, 4'b0000, 0, 1, 4'b0010, 0, 2));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(1, 8, 0, 4'b0000, 0, 1, 4'b0000, 1, 2));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(1, 9, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(0, 11'h7FF, 1, 4'b0001, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(1, 11'h7FF, 1, 4'b0001, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(0, 300, 0, 4'b0000, 1, 0, 4'b0000, 0, 2));
        vecs.push_back(v(1, 300, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(0, 300, 0, 4'b1111, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(1, 300, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(0, 300, 1, 4'b0000, 1, 0, 4'b0000, 0, 2));
        vecs.push_back(v(1, 300, 0, 4'b0000, 0, 1, 4'b0000, 1, 2));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 2));
        vecs.push_back(v(1, 300, 1, 4'b1000, 0, 1, 4'b1000, 0, 3));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 3));
        vecs.push_back(v(0, 11'h7FF, 0, 4'b0000, 0, 0, 4'b0000, 0, 3));
        #1;
        check("reset", 0, 4'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        foreach (vecs[i]) begin
            step(vecs[i].sof, vecs[i].y, vecs[i].adr, vecs[i].bdr, vecs[i].brd);
            check($sformatf("vec%0d", i), vecs[i].crash, vecs[i].bh, vecs[i].ceil, vecs[i].cnt);
        end
        repeat (3) step(0, 200, 1, 4'b0001, 0);
        step(1, 200, 1, 4'b0001, 0);
        check("stuck_first_crash", 1, 4'b0001, 0, 4);
        late_crash = 0;
        step(0, 200, 1, 4'b0001, 0);
        late_crash += int'(crash);
        for (int f = 1; f <= 4; f++) begin
            repeat (3) begin
                step(0, 200, 1, 4'b0001, 0);
                late_crash += int'(crash);
            end
            step(1, 200, 1, 4'b0001, 0);
            check($sformatf("stuck_frame%0d", f), 0, 4'b0, 0, 4);
        end
        checks++;
        if (late_crash != 0) begin
            errors++;
            $display("FAIL stuck_wait: got %0d crash cycles, expected 0", late_crash);
        end
        repeat (3) step(0, 200, 1, 4'b0001, 0);
        check("rearm_no_early", 0, 4'b0, 0, 4);
        step(1, 200, 1, 4'b0001, 0);
        check("rearm_crash", 1, 4'b0001, 0, 5);
        step(0, 11'h7FF, 0, 4'b0, 0);
        step(0, 11'h7FF, 0, 4'b0, 0);
        exp_cnt = 5;
        for (int k = 0; k < 251; k++) begin
            step(1, 300, 1, 4'b0001, 0);
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            check($sformatf("sat_hit%0d", k), 1, 4'b0001, 0, 8'(exp_cnt));
            step(0, 11'h7FF, 0, 4'b0, 0);
            step(0, 11'h7FF, 0, 4'b0, 0);
        end
        step(1, 300, 1, 4'b0001, 0);
        check("sat_hold", 1, 4'b0001, 0, 255);
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset_report", 0, 4'b0, 0, 0);
        #1;
        resetN = 1'b1;
        step(0, 11'h7FF, 0, 4'b0, 0);
        check("post_reset_idle", 0, 4'b0, 0, 0);
        step(1, 300, 1, 4'b0100, 0);
        check("post_reset_armed", 1, 4'b0100, 0, 1);
        step(0, 11'h7FF, 0, 4'b0, 0);
        check("post_reset_drop", 0, 4'b0, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
